// File: rtl/demux_1to4_buf.sv
// 1-to-4 word demultiplexer. Each output channel has its own 2-entry FWFT buffer,
// so a stalled consumer only back-pressures words addressed to its own channel.

module demux_1to4_buf_chan #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [ANCHO-1:0] dato_i,
  input  logic             listo_i,
  output logic [ANCHO-1:0] dato_o,
  output logic             valido_o,
  output logic [1:0]       cnt_o,
  output logic             rdy_o
);
  logic [1:0][ANCHO-1:0] mem_q, mem_d;
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ANCHO-1:0]      head_q, head_d;
  logic                  vld_q, vld_d;
  logic                  pop;

  assign pop   = vld_q && listo_i;
  // A full channel can still take a word on the edge its head is popped.
  assign rdy_o = (cnt_q != 2'd2) || listo_i;

  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = dato_i;
    wr_d  = wr_q ^ push_i;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
    vld_d = (cnt_d != 2'd0);
    // Head is registered from next-state storage so it is glitch-free and
    // keeps its last value once the channel drains.
    head_d = vld_d ? mem_d[rd_d] : head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      head_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      vld_q  <= vld_d;
    end
  end

  assign dato_o   = head_q;
  assign valido_o = vld_q;
  assign cnt_o    = cnt_q;
endmodule

module demux_1to4_buf #(
  parameter int ANCHO = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANCHO-1:0]   in_dato,
  input  logic [1:0]         in_sel,
  input  logic               in_valido,
  output logic               in_listo,
  output logic [4*ANCHO-1:0] out_dato,
  output logic [3:0]         out_valido,
  input  logic [3:0]         out_listo,
  output logic [7:0]         ocupacion
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] rdy;

  assign in_listo = rdy[in_sel];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_chan
    logic push;
    assign push = in_valido && in_listo && (in_sel == 2'(g));

    demux_1to4_buf_chan #(.ANCHO(ANCHO)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (push),
      .dato_i   (in_dato),
      .listo_i  (out_listo[g]),
      .dato_o   (out_dato[g*ANCHO +: ANCHO]),
      .valido_o (out_valido[g]),
      .cnt_o    (ocupacion[2*g +: 2]),
      .rdy_o    (rdy[g])
    );
  end
endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: four-queue reference model checked every cycle, plus
// directed scenarios with literal expectations and a random soak.

module tb_demux_1to4_buf;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_dato = '0;
  logic [1:0]     in_sel = '0;
  logic           in_valido = 1'b0;
  logic           in_listo;
  logic [4*W-1:0] out_dato;
  logic [3:0]     out_valido;
  logic [3:0]     out_listo = '0;
  logic [7:0]     ocupacion;

  demux_1to4_buf #(.ANCHO(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_dato(in_dato), .in_sel(in_sel),
    .in_valido(in_valido), .in_listo(in_listo), .out_dato(out_dato),
    .out_valido(out_valido), .out_listo(out_listo), .ocupacion(ocupacion)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [W-1:0] mq[4][$];    // reference contents per channel
  logic [W-1:0] plog[4][$];  // words the DUT handed to each consumer
  bit           acc;
  bit           mpush;
  bit           prev_vld[4];
  logic [W-1:0] prev_dat[4];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: a push goes to queue in_sel if it has room or its head leaves.
  always @(posedge clk) begin
    if (rst_n) begin
      mpush = in_valido && ((mq[in_sel].size() < 2) || out_listo[in_sel]);
      for (int i = 0; i < 4; i++) begin
        if (out_valido[i] && out_listo[i]) plog[i].push_back(out_dato[i*W +: W]);
        if (mq[i].size() > 0 && out_listo[i]) void'(mq[i].pop_front());
      end
      if (mpush) mq[in_sel].push_back(in_dato);
      acc = mpush;
    end
  end

  always @(negedge rst_n) for (int i = 0; i < 4; i++) mq[i].delete();

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valido[%0d]", i), 64'(out_valido[i]), 64'(mq[i].size() > 0));
        chk($sformatf("ocupacion[%0d]", i), 64'(ocupacion[2*i +: 2]), 64'(mq[i].size()));
        if (mq[i].size() > 0) chk($sformatf("dato[%0d]", i), 64'(out_dato[i*W +: W]), 64'(mq[i][0]));
        if (prev_vld[i] && !out_listo[i])
          chk($sformatf("stable[%0d]", i), 64'(out_dato[i*W +: W]), 64'(prev_dat[i]));
        prev_vld[i] = out_valido[i];
        prev_dat[i] = out_dato[i*W +: W];
      end
      chk("in_listo", 64'(in_listo), 64'((mq[in_sel].size() < 2) || out_listo[in_sel]));
    end else begin
      for (int i = 0; i < 4; i++) prev_vld[i] = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] l);
    #1;
    in_valido = v; in_sel = s; in_dato = d; out_listo = l;
  endtask

  task automatic clr_log();
    for (int i = 0; i < 4; i++) plog[i].delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valido", 64'(out_valido), 64'h0);
    chk("rst_ocupacion", 64'(ocupacion), 64'h0);
    chk("rst_dato", 64'(out_dato), 64'h0);
    #2 rst_n = 1'b1;
    #1 chk("rst_in_listo", 64'(in_listo), 64'h1);

    // Single word to channel c, popped immediately.
    clr_log();
    drive(1, 2, 16'hA5, 4'hF);
    @(negedge clk);
    chk("single_valido", 64'(out_valido), 64'h4);
    chk("single_dato", 64'(out_dato[2*W +: W]), 64'hA5);
    chk("single_ocup", 64'(ocupacion), 64'h10);
    drive(0, 2, 16'h0, 4'hF);
    @(negedge clk);
    chk("single_drain_ocup", 64'(ocupacion), 64'h0);
    chk("single_drain_valido", 64'(out_valido), 64'h0);

    // Fill channel b while its consumer stalls; the third word must wait.
    clr_log();
    drive(1, 1, 16'h11, 4'b1101);
    @(negedge clk); drive(1, 1, 16'h22, 4'b1101);
    @(negedge clk);
    chk("fill_ocup", 64'(ocupacion[3:2]), 64'h2);
    drive(1, 1, 16'h33, 4'b1101);
    #1 chk("fill_in_listo", 64'(in_listo), 64'h0);
    @(negedge clk);
    chk("fill_hold_ocup", 64'(ocupacion[3:2]), 64'h2);
    chk("fill_hold_head", 64'(out_dato[W +: W]), 64'h11);
    drive(1, 1, 16'h33, 4'b1101);
    @(negedge clk);
    drive(1, 1, 16'h33, 4'b1111);
    #1 chk("fill_popfree_listo", 64'(in_listo), 64'h1);
    @(negedge clk);
    chk("fill_after_pop_ocup", 64'(ocupacion[3:2]), 64'h2);
    drive(0, 1, 16'h0, 4'hF);
    repeat (4) @(negedge clk);
    chk("fill_order_n", 64'(plog[1].size()), 64'd3);
    if (plog[1].size() == 3) begin
      chk("fill_order0", 64'(plog[1][0]), 64'h11);
      chk("fill_order1", 64'(plog[1][1]), 64'h22);
      chk("fill_order2", 64'(plog[1][2]), 64'h33);
    end

    // Channel a full and stalled must not block channel d.
    drive(1, 0, 16'hC1, 4'b1110);
    @(negedge clk); drive(1, 0, 16'hC2, 4'b1110);
    @(negedge clk); drive(1, 3, 16'h5A, 4'b1110);
    #1 chk("iso_in_listo", 64'(in_listo), 64'h1);
    @(negedge clk);
    chk("iso_valido_d", 64'(out_valido[3]), 64'h1);
    chk("iso_dato_d", 64'(out_dato[3*W +: W]), 64'h5A);
    chk("iso_ocup_a", 64'(ocupacion[1:0]), 64'h2);
    chk("iso_head_a", 64'(out_dato[W-1:0]), 64'hC1);
    drive(0, 0, 16'h0, 4'hF);
    repeat (3) @(negedge clk);

    // Round-robin burst of 16 words with every consumer ready.
    clr_log();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      drive(1, 2'(k % 4), 16'(16'h40 + k), 4'hF);
      #1 chk("rr_in_listo", 64'(in_listo), 64'h1);
    end
    @(negedge clk); drive(0, 0, 16'h0, 4'hF);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rr_count", 64'(plog[i].size()), 64'd4);
      if (plog[i].size() == 4)
        for (int j = 0; j < 4; j++) chk("rr_word", 64'(plog[i][j]), 64'(16'h40 + 4*j + i));
    end

    // Asynchronous reset with two channels full.
    drive(1, 0, 16'hA0, 4'h0);
    @(negedge clk); drive(1, 0, 16'hA1, 4'h0);
    @(negedge clk); drive(1, 2, 16'hB0, 4'h0);
    @(negedge clk); drive(1, 2, 16'hB1, 4'h0);
    @(negedge clk); drive(0, 0, 16'h0, 4'h0);
    @(negedge clk);
    chk("mid_pre_ocup", 64'(ocupacion), 64'h22);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valido", 64'(out_valido), 64'h0);
    chk("mid_rst_ocup", 64'(ocupacion), 64'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    clr_log();
    drive(0, 0, 16'h0, 4'hF);
    repeat (4) @(negedge clk);
    chk("mid_post_valido", 64'(out_valido), 64'h0);
    chk("mid_post_log", 64'(plog[0].size() + plog[1].size() + plog[2].size() + plog[3].size()), 64'd0);

    // Random soak; a refused word is held until accepted.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      #1;
      if (!(in_valido && !acc)) begin
        in_valido = ($urandom_range(0, 3) != 0);
        in_sel    = 2'($urandom_range(0, 3));
        in_dato   = W'($urandom);
      end
      out_listo = 4'($urandom_range(0, 15));
    end
    @(negedge clk); drive(0, 0, 16'h0, 4'hF);
    repeat (4) @(negedge clk);
    chk("soak_empty", 64'(out_valido), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
